// File: rtl/frame_stream_pkg.sv
// Shared types and sizing helpers for the frame streamer.
package frame_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } state_t;

    function automatic int pix_count(input int width, input int height);
        return width * height;
    endfunction

    // Never narrower than one bit, even for a single-pixel frame.
    function automatic int addr_w(input int width, input int height);
        int n;
        n = width * height;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_streamer_skid.sv
// Two-entry output buffer behind a one-cycle-latency RAM; latency 0 (RAM data bypasses when empty).
// Holds data/valid stable under backpressure; reports free slots net of the read in flight.
module stream_skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] ret_data_i,
    input  logic         y_ready_i,
    output logic [W-1:0] y_data_o,
    output logic         y_valid_o,
    output logic [1:0]   free_o
);

    logic         inflight_q;
    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic         pop;

    assign y_valid_o = (cnt_q != 2'd0) || inflight_q;
    assign y_data_o  = (cnt_q != 2'd0) ? ent0_q : (inflight_q ? ret_data_i : '0);
    assign pop       = y_valid_o && y_ready_i;
    assign free_o    = 2'd2 - cnt_q - {1'b0, inflight_q};

    // Logical queue is {stored entries, returning RAM word}; pop removes its head.
    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        case (cnt_q)
            2'd0: begin
                if (inflight_q && !pop) begin
                    ent0_d = ret_data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop) begin
                    if (inflight_q) ent0_d = ret_data_i;
                    else            cnt_d  = 2'd0;
                end else if (inflight_q) begin
                    ent1_d = ret_data_i;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            inflight_q <= push_i;
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// Streams a WIDTH x HEIGHT frame from a sync RAM as a valid/ready producer; first pixel 2 cycles after start.
// Honours ready backpressure losslessly; FRAME_STREAMER_PATTERN_EN adds a synthetic ramp source.
module frame_streamer
    import frame_stream_pkg::*;
#(
    parameter int W      = 32,
    parameter int W_FRAC = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int GAP    = 4,
    localparam int ADDR_W = addr_w(WIDTH, HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
`ifdef FRAME_STREAMER_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [W-1:0]      rd_data,
    output logic [W-1:0]      y_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int PIX   = pix_count(WIDTH, HEIGHT);
    localparam int CNT_W = ADDR_W + 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0]  PIX_L    = CNT_W'(PIX);
    localparam logic [ADDR_W-1:0] PX_LAST  = ADDR_W'(PIX - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP - 1);

    if (GAP < 1 || W_FRAC >= W) begin : g_bad_params
        $error("frame_streamer: GAP must be >= 1 and W_FRAC < W");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] px_cnt_q, px_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              issue;
    logic              hs;
    logic [1:0]        free;
    logic [W-1:0]      ret_data;

    assign rd_addr    = rd_cnt_q[ADDR_W-1:0];
    assign hs         = y_valid && y_ready;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_GAP) && (gap_cnt_q == '0);

`ifdef FRAME_STREAMER_PATTERN_EN
    // Ramp source mimics the RAM's one-cycle latency so the buffer sees identical timing.
    logic [ADDR_W-1:0] pat_addr_q;
    always_ff @(posedge clk) begin
        if (reset)      pat_addr_q <= '0;
        else if (issue) pat_addr_q <= rd_addr;
    end
    assign rd_en    = issue && !pattern_sel;
    assign ret_data = pattern_sel ? (W'(pat_addr_q) << W_FRAC) : rd_data;
`else
    assign rd_en    = issue;
    assign ret_data = rd_data;
`endif

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        px_cnt_d  = px_cnt_q;
        gap_cnt_d = gap_cnt_q;
        issue     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_STREAM;
                    rd_cnt_d = '0;
                    px_cnt_d = '0;
                end
            end
            ST_STREAM: begin
                if (rd_cnt_q < PIX_L && free != 2'd0) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (hs) begin
                    if (px_cnt_q == PX_LAST) begin
                        state_d   = ST_GAP;
                        px_cnt_d  = '0;
                        gap_cnt_d = '0;
                        rd_cnt_d  = '0;
                    end else begin
                        px_cnt_d = px_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // Pixel 0 is fetched in the last gap cycle so valid rises right after the gap.
                    if (continuous) begin
                        state_d  = ST_STREAM;
                        issue    = 1'b1;
                        rd_cnt_d = CNT_W'(1);
                        px_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            px_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            px_cnt_q  <= px_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    stream_skid_buffer #(.W(W)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_i     (issue),
        .ret_data_i (ret_data),
        .y_ready_i  (y_ready),
        .y_data_o   (y_data),
        .y_valid_o  (y_valid),
        .free_o     (free)
    );

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer at WIDTH=4, HEIGHT=2, GAP=2 with a mem[i]=i+100 RAM model.
module tb_frame_streamer;

    localparam int W = 32, W_FRAC = 16, WIDTH = 4, HEIGHT = 2, GAP = 2;
    localparam int PIX = WIDTH * HEIGHT;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset, start, continuous, y_ready;
    logic              rd_en, y_valid, busy, frame_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data = '0;
    logic [W-1:0]      y_data;
    logic [W-1:0]      mem [PIX];
`ifdef FRAME_STREAMER_PATTERN_EN
    logic              pattern_sel = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    frame_streamer #(.W(W), .W_FRAC(W_FRAC), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .GAP(GAP)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
`ifdef FRAME_STREAMER_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .y_data     (y_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic              start, ready, cont, rst, chk;
        logic              valid;
        logic [W-1:0]      data;
        logic              rd_en;
        logic [ADDR_W-1:0] addr;
        logic              busy, done;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic s, r, c, rs, ck, v, input int d, input logic re,
                        input int a, input logic b, dn);
        vec_t t;
        t.start = s; t.ready = r; t.cont = c; t.rst = rs; t.chk = ck;
        t.valid = v; t.data = W'(d); t.rd_en = re; t.addr = ADDR_W'(a);
        t.busy = b; t.done = dn;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst; start = tbl[i].start;
            y_ready = tbl[i].ready; continuous = tbl[i].cont;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("%s[%0d].valid", tag, i), W'(y_valid), W'(tbl[i].valid));
                if (tbl[i].valid) check($sformatf("%s[%0d].data", tag, i), y_data, tbl[i].data);
                check($sformatf("%s[%0d].rd_en", tag, i), W'(rd_en), W'(tbl[i].rd_en));
                if (tbl[i].rd_en) check($sformatf("%s[%0d].rd_addr", tag, i), W'(rd_addr), W'(tbl[i].addr));
                check($sformatf("%s[%0d].busy", tag, i), W'(busy), W'(tbl[i].busy));
                check($sformatf("%s[%0d].frame_done", tag, i), W'(frame_done), W'(tbl[i].done));
            end
        end
        tbl.delete();
    endtask

    // Rows 0..3: reset, idle check, start (cycle N=2), first read.
    task automatic build_prologue();
        push(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic build_single(input logic extra_start);
        build_prologue();
        for (int k = 4; k <= 11; k++)
            push(extra_start && (k == 6), 1, 0, 0, 1, 1, 100 + k - 4, k <= 10, k - 3, 1, 0);
        push(extra_start, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        push(extra_start, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic build_backpressure();
        build_prologue();
        for (int k = 4; k <= 6; k++)
            push(0, 1, 0, 0, 1, 1, 100 + k - 4, 1, k - 3, 1, 0);
        push(0, 0, 0, 0, 1, 1, 103, 1, 4, 1, 0);
        push(0, 0, 0, 0, 1, 1, 103, 0, 0, 1, 0);
        push(0, 0, 0, 0, 1, 1, 103, 0, 0, 1, 0);
        push(0, 1, 0, 0, 1, 1, 103, 0, 0, 1, 0);
        push(0, 1, 0, 0, 1, 1, 104, 1, 5, 1, 0);
        push(0, 1, 0, 0, 1, 1, 105, 1, 6, 1, 0);
        push(0, 1, 0, 0, 1, 1, 106, 1, 7, 1, 0);
        push(0, 1, 0, 0, 1, 1, 107, 0, 0, 1, 0);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        push(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int npix, ndone, naddr0, run, nruns, exp_addr, nrd, guard;
        logic seen_valid;

        for (int i = 0; i < PIX; i++) mem[i] = W'(i + 100);
        reset = 1'b1; start = 1'b0; continuous = 1'b0; y_ready = 1'b1;

        build_single(1'b0);
        run_table("single");
        check("idle.data", y_data, '0);

        build_backpressure();
        run_table("bp");

        build_single(1'b1);
        run_table("start_ignored");

        // Three back-to-back frames in continuous mode.
        @(negedge clk); start = 1'b1; continuous = 1'b1;
        npix = 0; ndone = 0; naddr0 = 0; run = 0; nruns = 0; exp_addr = 0;
        seen_valid = 1'b0; guard = 0;
        do begin
            cycle();
            start = 1'b0;
            guard++;
            if (rd_en) begin
                check($sformatf("cont.rd_addr[%0d]", nrd), W'(rd_addr), W'(exp_addr));
                if (rd_addr == '0) naddr0++;
                exp_addr = (exp_addr + 1) % PIX;
                nrd++;
            end
            if (y_valid && y_ready) begin
                check($sformatf("cont.data[%0d]", npix), y_data, W'(100 + npix % PIX));
                npix++;
            end
            if (y_valid) begin
                if (run > 0) begin
                    check($sformatf("cont.gap_len[%0d]", nruns), W'(run), W'(GAP));
                    nruns++;
                end
                run = 0;
                seen_valid = 1'b1;
            end else if (seen_valid) begin
                run++;
            end
            if (frame_done) begin
                ndone++;
                if (ndone == 3) continuous = 1'b0;
            end
        end while (!(ndone == 3 && !busy) && guard < 200);
        check("cont.pixels", W'(npix), W'(3 * PIX));
        check("cont.frame_done_count", W'(ndone), 32'd3);
        check("cont.addr0_reads", W'(naddr0), 32'd3);
        check("cont.gaps", W'(nruns), 32'd2);
        check("cont.idle_at_end", W'(busy), 32'd0);

        // Reset with two pixels buffered and ready low.
        @(negedge clk); start = 1'b1; y_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); y_ready = 1'b0;
        @(negedge clk);
        cycle();
        check("rst.held_valid", W'(y_valid), 32'd1);
        check("rst.held_data", y_data, 32'd100);
        check("rst.full_no_read", W'(rd_en), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; y_ready = 1'b1;
        #1;
        check("rst.valid", W'(y_valid), 32'd0);
        check("rst.busy", W'(busy), 32'd0);
        check("rst.data", y_data, 32'd0);
        check("rst.rd_en", W'(rd_en), 32'd0);
        check("rst.frame_done", W'(frame_done), 32'd0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        check("rst.restart_rd_en", W'(rd_en), 32'd1);
        check("rst.restart_addr", W'(rd_addr), 32'd0);
        cycle();
        check("rst.restart_valid", W'(y_valid), 32'd1);
        check("rst.restart_data0", y_data, 32'd100);
        cycle();
        check("rst.restart_data1", y_data, 32'd101);
        guard = 0;
        while (busy && guard < 40) begin cycle(); guard++; end
        check("rst.frame_completes", W'(busy), 32'd0);

`ifdef FRAME_STREAMER_PATTERN_EN
        pattern_sel = 1'b1;
        @(negedge clk); start = 1'b1;
        npix = 0; nrd = 0; guard = 0;
        do begin
            cycle();
            start = 1'b0;
            guard++;
            if (rd_en) nrd++;
            if (y_valid && y_ready) begin
                check($sformatf("pat.data[%0d]", npix), y_data, W'(npix) << W_FRAC);
                npix++;
            end
        end while ((busy || guard < 2) && guard < 40);
        check("pat.pixels", W'(npix), W'(PIX));
        check("pat.rd_en_count", W'(nrd), 32'd0);
        pattern_sel = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Frame source for the image pipeline: reads a WIDTH×HEIGHT frame, row-major, from a synchronous frame-buffer RAM and drives it as a `dstream` producer into the convolution stage.
- `valid` is held high and gap-free for the whole frame.
- `valid` drops for at least GAP cycles between frames, so the consumer's rising-edge frame detect restarts its pixel counter.
- Honours `ready` backpressure without losing or duplicating pixels despite the RAM's one-cycle read latency.

## Interface
Parameters:
- W, 32: pixel width (signed fixed point).
- W_FRAC, 16: fractional bits; used only by the test pattern.
- WIDTH, 320: pixels per line.
- HEIGHT, 240: lines per frame.
- GAP, 4: idle cycles with `valid` low between frames; minimum 1.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to stream one frame; honoured only in IDLE.
- continuous  in  1  sampled at the end of GAP; 1 = start the next frame automatically.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address; ADDR_W = $clog2(WIDTH*HEIGHT).
- rd_data  in  W  RAM read data, valid the cycle after `rd_en`.
- y  dstream.out  W  pixel stream (`data`, `valid` out; `ready` in).
- busy  out  1  high in STREAM and GAP.
- frame_done  out  1  one-cycle pulse the cycle after the last pixel handshake.

## Operation
- FSM states: IDLE, STREAM, GAP.
  - IDLE → STREAM on `start`.
  - STREAM → GAP after handshake of pixel WIDTH*HEIGHT-1.
  - GAP → STREAM after GAP cycles if `continuous` = 1; otherwise GAP → IDLE.
- `start` is ignored in STREAM and GAP.
- Read counter: counts 0 .. WIDTH*HEIGHT-1, resets to 0 at each frame start. `rd_en` is issued only when the output buffer has a free slot once in-flight reads are counted; no reads are issued past the last address.
- Output buffer: 2 entries (output register plus skid).
  - Prevents overflow when `ready` drops while a read is in flight.
  - Under continuous `ready` = 1, sustains 1 pixel/cycle.
- `dstream` rules:
  - Once `y.valid` = 1, `y.data` and `y.valid` are held stable until `ready` = 1.
  - Handshake = `valid & ready`.
  - Within a frame, `y.valid` never deasserts before the last pixel while data is available. The RAM is always ready, so `valid` is continuous within a frame.
- Pixel order: `rd_addr` = row*WIDTH + col; no skipping or cropping. Border handling belongs to the consumer.
- `frame_done` asserts once per frame, coincident with entering GAP.
- Reset mid-operation: the next cycle shows state IDLE, both buffer entries flushed, any in-flight read discarded, counters 0.
- Reset values: `y.valid` 0, `y.data` 0, `rd_en` 0, `rd_addr` 0, `busy` 0, `frame_done` 0.

## Timing
- `start` sampled in cycle N:
  - cycle N+1: `rd_en` = 1, `rd_addr` = 0.
  - cycle N+2: `y.valid` = 1, `y.data` = mem[0].
- Steady state with `ready` = 1: one pixel per cycle. The last handshake occurs in cycle N+1+WIDTH*HEIGHT.
- Backpressure: after `ready` has been low for ≥2 cycles, `rd_en` = 0. The first handshake after `ready` returns presents the held pixel; throughput resumes at 1/cycle within 1 cycle.
- GAP: `y.valid` is 0 for exactly GAP cycles after the last handshake.
  - In continuous mode, `rd_en` for pixel 0 of the next frame is issued in the last GAP cycle.
  - `y.valid` rises in the cycle after GAP ends.

## Configuration
- `FRAME_STREAMER_PATTERN_EN` defined:
  - Adds input `pattern_sel` (1 bit).
  - With `pattern_sel` = 1: `rd_en` stays 0 and `y.data` = (pixel index) << W_FRAC, truncated to W bits.
  - Sequencing, gap and handshakes are unchanged.
- Macro undefined: no `pattern_sel` port and all data comes from `rd_data`.

## Structure
- Package `frame_stream_pkg`:
  - state enum (IDLE, STREAM, GAP);
  - ADDR_W helper function;
  - PIX_COUNT = WIDTH*HEIGHT helper.
- Sub-module `stream_skid_buffer` (2-entry, parameter W): takes RAM return data and in-flight tracking in, drives `y.data`/`y.valid` out, and reports free-slot count to the read issuer.
- Top level holds the FSM, read/pixel counters and gap counter.

## Test plan
- WIDTH=4, HEIGHT=2, GAP=2, RAM mem[i]=i+100, `ready`=1, `start` pulse:
  - `y.data` = 100..107 on 8 consecutive cycles starting at N+2;
  - `frame_done` once;
  - `y.valid` low 2 cycles;
  - then IDLE.
- Same config, `ready` low for 3 cycles after pixel 3 is presented: pixel 3 held stable, then sequence 104..107 with no loss or duplication; `rd_en` = 0 while full.
- `continuous` = 1 for 3 frames: exactly GAP cycles of `valid` = 0 between frames; each frame restarts at `rd_addr` 0; 3 `frame_done` pulses.
- `start` pulsed during STREAM and during GAP: ignored; output identical to the single-frame case.
- `reset` asserted mid-frame with `ready` = 0 and 2 pixels buffered: next cycle `y.valid` = 0 and `busy` = 0; a subsequent `start` streams from mem[0].
- `FRAME_STREAMER_PATTERN_EN` defined, `pattern_sel` = 1, W_FRAC=16: `y.data` = 0x00000, 0x10000, 0x20000 ...; `rd_en` never asserted.
